// File: rtl/scumvcontroller_uart_framer_if.sv
// rtl/scumvcontroller_uart_framer_if.sv - stream bundle between the framer, its command source, the UART and the response sink
//
// Signals (directions as seen from the framer, modport master):
//   cmd_valid/cmd_ready/cmd_mode            command start handshake, mode 0 = ASC, 1 = STL
//   payload_valid/payload_ready/payload_data payload bytes from the command source
//   tx_valid/tx_ready/tx_data               byte stream toward the UART transmitter
//   rx_valid/rx_ready/rx_data               byte stream from the UART receiver
//   rsp_valid/rsp_ready/rsp_data/rsp_last   response stream toward the consumer
// Modport slave is the mirror image, for the environment driving the framer.

interface scumvcontroller_uart_framer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_mode;

    logic       payload_valid;
    logic       payload_ready;
    logic [7:0] payload_data;

    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;

    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] rx_data;

    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_last;

    modport master (
        input  cmd_valid,
        output cmd_ready,
        input  cmd_mode,
        input  payload_valid,
        output payload_ready,
        input  payload_data,
        output tx_valid,
        input  tx_ready,
        output tx_data,
        input  rx_valid,
        output rx_ready,
        input  rx_data,
        output rsp_valid,
        input  rsp_ready,
        output rsp_data,
        output rsp_last
    );

    modport slave (
        output cmd_valid,
        input  cmd_ready,
        output cmd_mode,
        output payload_valid,
        input  payload_ready,
        output payload_data,
        input  tx_valid,
        output tx_ready,
        input  tx_data,
        output rx_valid,
        input  rx_ready,
        output rx_data,
        input  rsp_valid,
        output rsp_ready,
        input  rsp_data,
        input  rsp_last
    );
endinterface

// File: rtl/scumvcontroller_uart_framer.sv
// rtl/scumvcontroller_uart_framer.sv - host-side ASC/STL command framer and response collector for the SCuM-V UART protocol
//
// Frames a command as "asc+"/"stl+" followed by a fixed-length payload toward a
// UART transmitter, then passes the fixed-length response from the UART
// receiver onto the response stream.
//
// Ports:
//   clk          single clock, rising edge
//   reset        asynchronous, active-high
//   bus          scumvcontroller_uart_framer_if.master (cmd, payload, tx, rx, rsp streams)
//   busy         state != IDLE
//   timeout_err  one-cycle pulse when a response stalls too long
//   debug_state  {2'b0, state}
//   txn_count    completed transactions, wraps 255 -> 0
//
// Optional feature: define FRAMER_TIMEOUT_EN to compile in the response
// timeout (TIMEOUT_CYCLES idle cycles between response bytes). Without it the
// framer waits in RESPONSE indefinitely and timeout_err is tied low.

module scumvcontroller_uart_framer #(
    parameter int ASC_PACKET_SIZE   = 22,
    parameter int STL_PACKET_SIZE   = 16,
    parameter int ASC_RESPONSE_SIZE = 1,
    parameter int STL_RESPONSE_SIZE = 16,
    parameter int TIMEOUT_CYCLES    = 1_000_000
) (
    input  logic                                 clk,
    input  logic                                 reset,
    scumvcontroller_uart_framer_if.master        bus,
    output logic                                 busy,
    output logic                                 timeout_err,
    output logic [3:0]                           debug_state,
    output logic [7:0]                           txn_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREFIX   = 2'd1,
        PAYLOAD  = 2'd2,
        RESPONSE = 2'd3
    } state_t;

    // Index of the final byte of each phase, in counter width.
    localparam logic [7:0] ASC_PAY_LAST = 8'(ASC_PACKET_SIZE - 1);
    localparam logic [7:0] STL_PAY_LAST = 8'(STL_PACKET_SIZE - 1);
    localparam logic [7:0] ASC_RSP_LAST = 8'(ASC_RESPONSE_SIZE - 1);
    localparam logic [7:0] STL_RSP_LAST = 8'(STL_RESPONSE_SIZE - 1);
    localparam logic [7:0] PREFIX_LAST  = 8'd3;

    state_t     state;
    state_t     state_d;
    logic [7:0] cnt;
    logic [7:0] cnt_d;
    logic       mode;
    logic       mode_d;
    logic [7:0] txn_count_d;

    logic       cmd_fire;
    logic       tx_fire;
    logic       rx_fire;
    logic       timeout_hit;

    logic [7:0] pay_last;
    logic [7:0] rsp_last_idx;
    logic [7:0] prefix_byte;

    // Handshakes are derived from state and inputs directly so that the
    // pass-through outputs and the next-state logic share no loop.
    assign cmd_fire = (state == IDLE) && bus.cmd_valid;
    assign tx_fire  = ((state == PREFIX) && bus.tx_ready) ||
                      ((state == PAYLOAD) && bus.payload_valid && bus.tx_ready);
    assign rx_fire  = (state == RESPONSE) && bus.rx_valid && bus.rsp_ready;

    assign pay_last     = mode ? STL_PAY_LAST : ASC_PAY_LAST;
    assign rsp_last_idx = mode ? STL_RSP_LAST : ASC_RSP_LAST;

    // "asc+" = 61 73 63 2B, "stl+" = 73 74 6C 2B
    always_comb begin
        prefix_byte = 8'h2B;
        case (cnt[1:0])
            2'd0:    prefix_byte = mode ? 8'h73 : 8'h61;
            2'd1:    prefix_byte = mode ? 8'h74 : 8'h73;
            2'd2:    prefix_byte = mode ? 8'h6C : 8'h63;
            default: prefix_byte = 8'h2B;
        endcase
    end

`ifdef FRAMER_TIMEOUT_EN
    logic [31:0] tmo_cnt;
    logic        timeout_q;

    // A response transfer in the expiry cycle takes priority over the timeout.
    assign timeout_hit = (state == RESPONSE) && !rx_fire &&
                         (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));

    // Held at zero outside RESPONSE, so it is clear on entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt   <= 32'd0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_hit;
            if ((state != RESPONSE) || rx_fire || timeout_hit) begin
                tmo_cnt <= 32'd0;
            end else begin
                tmo_cnt <= tmo_cnt + 32'd1;
            end
        end
    end

    assign timeout_err = timeout_q;
`else
    wire unused_timeout_cfg = (TIMEOUT_CYCLES != 0);

    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            mode      <= 1'b0;
            txn_count <= 8'd0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            mode      <= mode_d;
            txn_count <= txn_count_d;
        end
    end

    always_comb begin
        state_d           = state;
        cnt_d             = cnt;
        mode_d            = mode;
        txn_count_d       = txn_count;

        bus.cmd_ready     = 1'b0;
        bus.payload_ready = 1'b0;
        bus.tx_valid      = 1'b0;
        bus.tx_data       = 8'h00;
        bus.rx_ready      = 1'b0;
        bus.rsp_valid     = 1'b0;
        bus.rsp_data      = 8'h00;
        bus.rsp_last      = 1'b0;

        case (state)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                // Stray receiver bytes between transactions are drained and dropped.
                bus.rx_ready  = 1'b1;
                if (cmd_fire) begin
                    mode_d  = bus.cmd_mode;
                    cnt_d   = 8'd0;
                    state_d = PREFIX;
                end
            end

            PREFIX: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = prefix_byte;
                if (tx_fire) begin
                    if (cnt == PREFIX_LAST) begin
                        cnt_d   = 8'd0;
                        state_d = PAYLOAD;
                    end else begin
                        cnt_d = cnt + 8'd1;
                    end
                end
            end

            PAYLOAD: begin
                bus.tx_valid      = bus.payload_valid;
                bus.tx_data       = bus.payload_data;
                bus.payload_ready = bus.tx_ready;
                if (tx_fire) begin
                    if (cnt == pay_last) begin
                        cnt_d   = 8'd0;
                        state_d = RESPONSE;
                    end else begin
                        cnt_d = cnt + 8'd1;
                    end
                end
            end

            RESPONSE: begin
                bus.rsp_valid = bus.rx_valid;
                bus.rsp_data  = bus.rx_data;
                bus.rx_ready  = bus.rsp_ready;
                bus.rsp_last  = bus.rx_valid && (cnt == rsp_last_idx);
                if (rx_fire) begin
                    if (cnt == rsp_last_idx) begin
                        cnt_d       = 8'd0;
                        state_d     = IDLE;
                        txn_count_d = txn_count + 8'd1;
                    end else begin
                        cnt_d = cnt + 8'd1;
                    end
                end else if (timeout_hit) begin
                    cnt_d   = 8'd0;
                    state_d = IDLE;
                end
            end

            default: begin
                cnt_d   = 8'd0;
                state_d = IDLE;
            end
        endcase
    end

    assign busy        = (state != IDLE);
    assign debug_state = {2'b00, state};

endmodule

// File: tb/tb_scumvcontroller_uart_framer.sv
// tb/tb_scumvcontroller_uart_framer.sv - scoreboard bench for the SCuM-V UART framer

module tb_scumvcontroller_uart_framer;

    logic       clk = 1'b0;
    logic       reset;
    logic       busy;
    logic       timeout_err;
    logic [3:0] debug_state;
    logic [7:0] txn_count;

    always #5 clk = ~clk;

    scumvcontroller_uart_framer_if bus();

    scumvcontroller_uart_framer #(
        .ASC_PACKET_SIZE   (22),
        .STL_PACKET_SIZE   (16),
        .ASC_RESPONSE_SIZE (1),
        .STL_RESPONSE_SIZE (16),
        .TIMEOUT_CYCLES    (100)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .busy        (busy),
        .timeout_err (timeout_err),
        .debug_state (debug_state),
        .txn_count   (txn_count)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [7:0] pay_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] exp_tx[$];
    logic [8:0] exp_rsp[$];

    bit drv_cmd_valid = 1'b0;
    bit drv_cmd_mode  = 1'b0;
    bit txr_toggle    = 1'b0;
    bit bp_en         = 1'b0;
    int rsp_block     = 0;
    int bp_cyc        = 0;
    int rsp_n         = 0;
    int hs_cyc        = -1;
    int tx_first      = 0;
    int tx_last       = 0;
    int tx_n          = 0;
    int c0            = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_cmd_ready"},     32'(bus.cmd_ready),     32'd1);
        check({tag, "_rx_ready"},      32'(bus.rx_ready),      32'd1);
        check({tag, "_tx_valid"},      32'(bus.tx_valid),      32'd0);
        check({tag, "_payload_ready"}, 32'(bus.payload_ready), 32'd0);
        check({tag, "_rsp_valid"},     32'(bus.rsp_valid),     32'd0);
        check({tag, "_busy"},          32'(busy),              32'd0);
        check({tag, "_debug_state"},   32'(debug_state),       32'd0);
        check({tag, "_timeout_err"},   32'(timeout_err),       32'd0);
    endtask

    // One clock: drive inputs at the falling edge, sample just after, score transfers.
    task automatic cycle();
        @(negedge clk);
        bus.cmd_valid     = drv_cmd_valid;
        bus.cmd_mode      = drv_cmd_mode;
        bus.payload_valid = (pay_q.size() != 0);
        bus.payload_data  = (pay_q.size() != 0) ? pay_q[0] : 8'h00;
        bus.tx_ready      = txr_toggle ? cyc[0] : 1'b1;
        bus.rx_valid      = (rx_q.size() != 0);
        bus.rx_data       = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
        bus.rsp_ready     = (rsp_block == 0);
        #1;
        if (rsp_block > 0) begin
            if (debug_state == 4'd3) begin
                check("bp_rx_ready", 32'(bus.rx_ready), 32'd0);
                bp_cyc++;
            end
            rsp_block--;
        end
        if (bus.cmd_valid && bus.cmd_ready) hs_cyc = cyc;
        if (bus.tx_valid && bus.tx_ready) begin
            if (exp_tx.size() == 0) check("tx_extra_byte", 32'(bus.tx_data), 32'hFFFF_FFFF);
            else check("tx_byte", 32'(bus.tx_data), 32'(exp_tx.pop_front()));
            if (tx_n == 0) tx_first = cyc;
            tx_last = cyc;
            tx_n++;
        end
        if (bus.payload_valid && bus.payload_ready) void'(pay_q.pop_front());
        if (bus.rx_valid && bus.rx_ready) void'(rx_q.pop_front());
        if (bus.rsp_valid && bus.rsp_ready) begin
            if (exp_rsp.size() == 0) check("rsp_extra_byte", 32'({bus.rsp_last, bus.rsp_data}), 32'hFFFF_FFFF);
            else check("rsp_byte_last", 32'({bus.rsp_last, bus.rsp_data}), 32'(exp_rsp.pop_front()));
            rsp_n++;
            if (bp_en && rsp_n == 5) rsp_block = 10;
        end
        cyc++;
    endtask

    // Queue the expected frame and payload, then perform the command handshake.
    task automatic start_cmd(input bit mode, input logic [7:0] pbase);
        int n;
        n = mode ? 16 : 22;
        if (mode) begin
            exp_tx.push_back(8'h73); exp_tx.push_back(8'h74);
            exp_tx.push_back(8'h6C); exp_tx.push_back(8'h2B);
        end else begin
            exp_tx.push_back(8'h61); exp_tx.push_back(8'h73);
            exp_tx.push_back(8'h63); exp_tx.push_back(8'h2B);
        end
        for (int i = 0; i < n; i++) begin
            exp_tx.push_back(8'(pbase + 8'(i)));
            pay_q.push_back(8'(pbase + 8'(i)));
        end
        tx_n = 0;
        rsp_n = 0;
        hs_cyc = -1;
        drv_cmd_valid = 1'b1;
        drv_cmd_mode  = mode;
        cycle();
        drv_cmd_valid = 1'b0;
        check("cmd_handshake", 32'(hs_cyc), 32'(cyc - 1));
    endtask

    task automatic run_txn(input bit mode, input logic [7:0] pbase, input logic [7:0] rbase);
        int m;
        m = mode ? 16 : 1;
        start_cmd(mode, pbase);
        for (int i = 0; i < m; i++) begin
            rx_q.push_back(8'(rbase + 8'(i)));
            exp_rsp.push_back({(i == m - 1), 8'(rbase + 8'(i))});
        end
        for (int k = 0; k < 2000 && (busy || exp_rsp.size() != 0); k++) cycle();
        check("txn_done_busy", 32'(busy), 32'd0);
        check("txn_rsp_drained", 32'(exp_rsp.size()), 32'd0);
        check("txn_tx_drained", 32'(exp_tx.size()), 32'd0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        pay_q.delete(); rx_q.delete(); exp_tx.delete(); exp_rsp.delete();
        drv_cmd_valid = 1'b0;
        bus.cmd_valid = 1'b0; bus.payload_valid = 1'b0; bus.rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_mode = 1'b0;
        bus.payload_valid = 1'b0; bus.payload_data = 8'h00;
        bus.tx_ready = 1'b1;
        bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
        bus.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check_idle("por");
        check("por_txn_count", 32'(txn_count), 32'd0);

        // ASC frame, everything ready
        run_txn(1'b0, 8'h00, 8'h5A);
        check("asc_first_tx_latency", 32'(tx_first), 32'(hs_cyc + 1));
        check("asc_tx_span", 32'(tx_last - tx_first), 32'd25);
        check("asc_tx_bytes", 32'(tx_n), 32'd26);
        check("asc_txn_count", 32'(txn_count), 32'd1);
        check("asc_back_idle", 32'(debug_state), 32'd0);

        // STL frame with tx_ready toggling
        txr_toggle = 1'b1;
        run_txn(1'b1, 8'hA0, 8'h10);
        txr_toggle = 1'b0;
        check("stl_tx_bytes", 32'(tx_n), 32'd20);
        check("stl_rsp_bytes", 32'(rsp_n), 32'd16);
        check("stl_txn_count", 32'(txn_count), 32'd2);

        // Response backpressure for 10 cycles mid-response
        bp_en = 1'b1;
        bp_cyc = 0;
        run_txn(1'b1, 8'h30, 8'hC0);
        bp_en = 1'b0;
        check("bp_blocked_cycles", 32'(bp_cyc), 32'd10);
        check("bp_txn_count", 32'(txn_count), 32'd3);

        // Stray rx byte while idle is drained, not forwarded
        rx_q.push_back(8'hFF);
        cycle();
        check("stray_drained", 32'(rx_q.size()), 32'd0);
        check("stray_no_rsp", 32'(bus.rsp_valid), 32'd0);
        check("stray_txn_count", 32'(txn_count), 32'd3);

        // ASC frame with no response
        start_cmd(1'b0, 8'h40);
        for (int k = 0; k < 200 && debug_state != 4'd3; k++) cycle();
        c0 = cyc - 1;
        check("noresp_in_response", 32'(debug_state), 32'd3);
        check("noresp_tx_drained", 32'(exp_tx.size()), 32'd0);
`ifdef FRAMER_TIMEOUT_EN
        for (int k = 0; k < 300 && !timeout_err; k++) cycle();
        check("timeout_delay", 32'(cyc - 1 - c0), 32'd100);
        check("timeout_in_idle", 32'(debug_state), 32'd0);
        cycle();
        check("timeout_pulse_width", 32'(timeout_err), 32'd0);
        check("timeout_busy", 32'(busy), 32'd0);
        check("timeout_txn_count", 32'(txn_count), 32'd3);
`else
        repeat (200) cycle();
        check("wait_busy", 32'(busy), 32'd1);
        check("wait_state", 32'(debug_state), 32'd3);
        check("wait_no_timeout", 32'(timeout_err), 32'd0);
`endif
        apply_reset();
        check_idle("rst2");
        check("rst2_txn_count", 32'(txn_count), 32'd0);

        // Asynchronous reset during payload byte 7
        start_cmd(1'b0, 8'h00);
        for (int k = 0; k < 100 && pay_q.size() > 15; k++) cycle();
        check("mid_payload_pos", 32'(pay_q.size()), 32'd15);
        check("mid_payload_state", 32'(debug_state), 32'd2);
        #1;
        reset = 1'b1;
        #1;
        check_idle("async_rst");
        check("async_rst_txn_count", 32'(txn_count), 32'd0);
        pay_q.delete(); rx_q.delete(); exp_tx.delete(); exp_rsp.delete();
        @(negedge clk);
        reset = 1'b0;
        run_txn(1'b1, 8'h50, 8'h60);
        check("post_rst_first_tx", 32'(tx_first), 32'(hs_cyc + 1));
        check("post_rst_txn_count", 32'(txn_count), 32'd1);

        // 256 back-to-back ASC transactions wrap txn_count
        apply_reset();
        for (int i = 0; i < 255; i++) run_txn(1'b0, 8'(i), 8'(i ^ 8'h5C));
        check("wrap_255", 32'(txn_count), 32'd255);
        run_txn(1'b0, 8'hEE, 8'h11);
        check("wrap_0", 32'(txn_count), 32'd0);
        check("wrap_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, tests run %0d", tests);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/scumvcontroller_uart_framer.md
# scumvcontroller_uart_framer

Host-side initiator for the SCuM-V controller's dual-mode UART protocol: frames an ASC (scan chain) or STL (TileLink) command as a prefixed byte stream, pushes it toward a UART transmitter, then collects the fixed-length response from the UART receiver and presents it on a response stream. Used in the bring-up FPGA for loopback self-test and for daisy-chaining a second controller. It sits between a command source (sequencer or soft core) and a standard `uart` instance.

## Interface
- `ASC_PACKET_SIZE`, 22: ASC payload bytes after prefix
- `STL_PACKET_SIZE`, 16: STL payload bytes after prefix
- `ASC_RESPONSE_SIZE`, 1: ASC response bytes
- `STL_RESPONSE_SIZE`, 16: STL response bytes
- `TIMEOUT_CYCLES`, 1_000_000: idle cycles allowed between response bytes (only with timeout compiled in)

- `clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-high
- `cmd_valid`  in  1  start request
- `cmd_ready`  out  1  high only in IDLE
- `cmd_mode`  in  1  0 = ASC, 1 = STL; sampled on cmd handshake
- `payload_valid`  in  1  payload byte available
- `payload_ready`  out  1  payload byte accepted
- `payload_data`  in  8  payload byte
- `tx_valid`  out  1  byte to UART TX
- `tx_ready`  in  1  UART TX accepts
- `tx_data`  out  8  byte to UART TX
- `rx_valid`  in  1  byte from UART RX
- `rx_ready`  out  1  framer accepts RX byte
- `rx_data`  in  8  byte from UART RX
- `rsp_valid`  out  1  response byte valid
- `rsp_ready`  in  1  consumer accepts
- `rsp_data`  out  8  response byte
- `rsp_last`  out  1  marks final response byte
- `busy`  out  1  state != IDLE
- `timeout_err`  out  1  one-cycle pulse on response timeout
- `debug_state`  out  4  {2'b0, state}
- `txn_count`  out  8  completed transactions, wraps 255 -> 0

## Operation
- Transfer on any stream = valid && ready in the same cycle. Byte counter `cnt` is 8 bits, shared across states.
- IDLE (0): `cmd_ready`=1, `rx_ready`=1 (stray RX bytes discarded). On cmd handshake: latch mode, cnt<=0, go PREFIX.
- PREFIX (1): `tx_valid`=1, `tx_data` = prefix[cnt]; ASC "asc+" = 0x61 0x73 0x63 0x2B, STL "stl+" = 0x73 0x74 0x6C 0x2B. On each tx transfer cnt++; on transfer with cnt==3: cnt<=0, go PAYLOAD.
- PAYLOAD (2): pass-through: `tx_valid`=`payload_valid`, `tx_data`=`payload_data`, `payload_ready`=`tx_ready`. On transfer with cnt==N-1 (N = ASC/STL_PACKET_SIZE by mode): cnt<=0, go RESPONSE; else cnt++.
- RESPONSE (3): pass-through: `rsp_valid`=`rx_valid`, `rsp_data`=`rx_data`, `rx_ready`=`rsp_ready`, `rsp_last` = (cnt==M-1), M = ASC/STL_RESPONSE_SIZE by mode. On transfer with cnt==M-1: go IDLE, cnt<=0, `txn_count`++; else cnt++.
- `payload_ready`=0 outside PAYLOAD; `tx_valid`=0 outside PREFIX/PAYLOAD; `rsp_valid`=0 and `rx_ready`=0 outside RESPONSE except `rx_ready`=1 in IDLE.
- Illegal state encodings return to IDLE next cycle.

## Timing
- Reset values: state IDLE, cnt 0, mode 0, `txn_count` 0, timeout counter 0, `timeout_err` 0; hence `cmd_ready`=1, `rx_ready`=1, all other outputs 0. Reset asserted mid-transaction aborts immediately (asynchronously); no partial frame resumes.
- cmd handshake at cycle T -> first prefix byte offered at T+1. Minimum frame: 4 + N tx cycles with `tx_ready` held high; no bubbles between prefix and payload.
- Pass-through paths are combinational (zero latency); only state, cnt, mode, counters are registered.
- `rsp_last` is valid only while `rsp_valid`=1.
- `txn_count` updates the cycle after the last response transfer; `busy` falls the same edge.
- `cmd_valid` asserted while busy is ignored (not queued).

## Configuration
- `FRAMER_TIMEOUT_EN` defined: 32-bit timeout counter clears on entry to RESPONSE and on every rx transfer, increments each other RESPONSE cycle; reaching `TIMEOUT_CYCLES`-1 without a transfer -> next cycle state IDLE, cnt 0, `timeout_err`=1 for exactly one cycle, `txn_count` unchanged. A transfer in the same cycle as expiry wins (no timeout).
- Undefined: no counter; RESPONSE waits indefinitely; `timeout_err` tied 0; `TIMEOUT_CYCLES` unused.

## Test plan
- ASC frame, all ready high: cmd_mode=0, payload 0x00..0x15 -> tx stream 61 73 63 2B 00..15 (26 bytes, contiguous); rx 0x5A -> rsp 0x5A with `rsp_last`=1; `txn_count`=1, back to IDLE.
- STL frame with `tx_ready` toggling every other cycle: payload 0xA0..0xAF -> tx 73 74 6C 2B A0..AF in order, no drops/duplicates; 16 rx bytes -> `rsp_last` only on 16th.
- Backpressure on rsp: `rsp_ready`=0 for 10 cycles mid-response -> `rx_ready`=0 those cycles, no byte lost; stray rx byte 0xFF in IDLE -> discarded, no `rsp_valid`.
- Timeout (macro defined, `TIMEOUT_CYCLES`=100): ASC frame, no rx -> `timeout_err` one-cycle pulse 100 cycles after RESPONSE entry, IDLE, `txn_count` unchanged; macro undefined -> stays in RESPONSE indefinitely.
- Reset asserted during PAYLOAD byte 7 -> outputs at reset values asynchronously; next STL command produces full prefix from 0x73.
- 256 back-to-back ASC transactions -> `txn_count` wraps to 0.
